systolic_mm_stream: RTL and testbench

//  Streaming, output-stationary NxN signed-integer matrix-multiply engine; computes C = A*B over a run-time inner dimension K.

---
 rtl/systolic_mm_stream.sv | 218 +++++++++++++++++++++
 tb/tb_systolic_mm_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_stream.sv
// systolic_mm_stream: streaming output-stationary NxN signed matrix multiply.
// Each accepted beat carries one column of A (iRow) and one row of B (iCol).
// Internal skew chains align the operands, so the caller does not pre-skew them.
// An IDLE/LOAD/FLUSH/DONE FSM handshakes beats in and holds the result until iAck.
// Optional feature macro: SATURATE_EN.
//   Defined: each accumulate clamps and the clamp is sticky per element.
//   Undefined: the accumulators wrap modulo 2^ACCW.
module systolic_mm_stream #(
  parameter int N        = 4,
  parameter int BITWIDTH = 8,
  parameter int ACCW     = 24,
  parameter int KW       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iStart,
  input  logic [KW-1:0]            iK,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [N*BITWIDTH-1:0]    iRow,
  input  logic [N*BITWIDTH-1:0]    iCol,
  output logic [N*N*ACCW-1:0]      oRes,
  output logic                     oValid,
  input  logic                     iAck,
  output logic                     oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  // The flush lasts 2N-1 cycles: 2(N-1) cycles of skew plus one MAC register.
  localparam int FW         = $clog2(2 * N);
  localparam int FLUSH_LAST = 2 * N - 2;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;

  logic start_w;   // start accepted this cycle; clears the whole datapath
  logic accept_w;  // beat accepted this cycle
  logic run_w;     // datapath advances (LOAD or FLUSH)

  assign start_w  = (state_q == S_IDLE) && iStart;
  assign accept_w = (state_q == S_LOAD) && iValid;
  assign run_w    = (state_q == S_LOAD) || (state_q == S_FLUSH);

  assign oReady = (state_q == S_LOAD);
  assign oValid = (state_q == S_DONE);
  assign oBusy  = (state_q != S_IDLE);

  // FSM state, latched K, beat counter and flush counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic for the start / load / flush / done sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          k_d     = iK;
          beat_d  = '0;
          flush_d = '0;
          state_d = (iK == '0) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept_w) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == k_q - 1'b1) begin
            flush_d = '0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST[FW-1:0]) state_d = S_DONE;
        else                               flush_d = flush_q + 1'b1;
      end
      S_DONE: begin
        if (iAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands that enter the west edge (A) and the north edge (B) of the array.
  logic signed [BITWIDTH-1:0] a_edge [N];
  logic signed [BITWIDTH-1:0] b_edge [N];

  // Skew chains. Row i of A and column j of B get i+1 and j+1 registers.
  // The extra register aligns beat arrival with the MAC stage.
  // Cycles without an accepted beat inject zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic signed [BITWIDTH-1:0] a_sk_q [gi+1];
    logic signed [BITWIDTH-1:0] b_sk_q [gi+1];

    // Shift the A and B operand skew chains while the array runs.
    always_ff @(posedge clk) begin
      if (reset || start_w) begin
        for (int p = 0; p <= gi; p++) begin
          a_sk_q[p] <= '0;
          b_sk_q[p] <= '0;
        end
      end else if (run_w) begin
        a_sk_q[0] <= accept_w ? signed'(iRow[gi*BITWIDTH +: BITWIDTH]) : '0;
        b_sk_q[0] <= accept_w ? signed'(iCol[gi*BITWIDTH +: BITWIDTH]) : '0;
        for (int p = 1; p <= gi; p++) begin
          a_sk_q[p] <= a_sk_q[p-1];
          b_sk_q[p] <= b_sk_q[p-1];
        end
      end
    end

    assign a_edge[gi] = a_sk_q[gi];
    assign b_edge[gi] = b_sk_q[gi];
  end

  // Forwarding registers: A moves east and B moves south. The last column/row has no consumer.
  logic signed [BITWIDTH-1:0] a_q   [N][N-1];
  logic signed [BITWIDTH-1:0] b_q   [N-1][N];
  logic signed [ACCW-1:0]     acc_q [N][N];

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [BITWIDTH-1:0]   a_op, b_op;
      logic signed [2*BITWIDTH-1:0] prod;
      logic signed [ACCW-1:0]       prod_ext;
      logic signed [ACCW-1:0]       acc_d;

      if (j == 0) begin : g_a_west
        assign a_op = a_edge[i];
      end else begin : g_a_inner
        assign a_op = a_q[i][j-1];
      end
      if (i == 0) begin : g_b_north
        assign b_op = b_edge[j];
      end else begin : g_b_inner
        assign b_op = b_q[i-1][j];
      end

      assign prod     = a_op * b_op;
      assign prod_ext = ACCW'(prod);  // sign-extending size cast

`ifdef SATURATE_EN
      localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
      localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
      logic              sat_q, sat_d;
      logic signed [ACCW:0] sum;

      // Saturating accumulate. The clamped value is held once the element has saturated.
      always_comb begin
        sum   = {acc_q[i][j][ACCW-1], acc_q[i][j]} + {prod_ext[ACCW-1], prod_ext};
        acc_d = sum[ACCW-1:0];
        sat_d = sat_q;
        if (sat_q) begin
          acc_d = acc_q[i][j];
        end else if (sum[ACCW] != sum[ACCW-1]) begin
          acc_d = sum[ACCW] ? ACC_MIN : ACC_MAX;
          sat_d = 1'b1;
        end
      end

      // Sticky saturation flag for this element.
      always_ff @(posedge clk) begin
        if (reset || start_w) sat_q <= 1'b0;
        else if (run_w)       sat_q <= sat_d;
      end
`else
      // Wrapping accumulate, modulo 2^ACCW.
      always_comb begin
        acc_d = acc_q[i][j] + prod_ext;
      end
`endif

      // Accumulator. It is frozen outside LOAD/FLUSH and is cleared on reset and on start.
      always_ff @(posedge clk) begin
        // NOTE: the accumulators need an explicit reset because oRes must read zero after reset.
        if (reset || start_w) acc_q[i][j] <= '0;
        else if (run_w)       acc_q[i][j] <= acc_d;
      end

      if (j < N - 1) begin : g_a_fwd
        // Pass A east to the next PE.
        always_ff @(posedge clk) begin
          if (reset || start_w) a_q[i][j] <= '0;
          else if (run_w)       a_q[i][j] <= a_op;
        end
      end
      if (i < N - 1) begin : g_b_fwd
        // Pass B south to the next PE.
        always_ff @(posedge clk) begin
          if (reset || start_w) b_q[i][j] <= '0;
          else if (run_w)       b_q[i][j] <= b_op;
        end
      end

      assign oRes[(i*N+j)*ACCW +: ACCW] = acc_q[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Directed bench for systolic_mm_stream (N=4, BITWIDTH=8, ACCW=16, KW=8).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_systolic_mm_stream;

  localparam int N    = 4;
  localparam int BW   = 8;
  localparam int ACCW = 16;
  localparam int KW   = 8;

  logic              clk;
  logic              reset;
  logic              iStart;
  logic [KW-1:0]     iK;
  logic              iValid;
  logic              oReady;
  logic [N*BW-1:0]   iRow;
  logic [N*BW-1:0]   iCol;
  logic [N*N*ACCW-1:0] oRes;
  logic              oValid;
  logic              iAck;
  logic              oBusy;

  systolic_mm_stream #(.N(N), .BITWIDTH(BW), .ACCW(ACCW), .KW(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .iStart(iStart),
    .iK    (iK),
    .iValid(iValid),
    .oReady(oReady),
    .iRow  (iRow),
    .iCol  (iCol),
    .oRes  (oRes),
    .oValid(oValid),
    .iAck  (iAck),
    .oBusy (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N*BW-1:0]     rows [N];
  logic [N*BW-1:0]     cols [N];
  logic [N*N*ACCW-1:0] exp_b;
  int                  lat_start;
  int                  lat_last;
  bit                  saw_ready;

  // Operands for A = I and B[k][j] = 4k+j+1. The expected product is C = B.
  task automatic load_identity();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        rows[k][i*BW +: BW] = (i == k) ? 8'd1 : 8'd0;
        cols[k][i*BW +: BW] = 8'(4 * k + i + 1);
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_b[(i*N+j)*ACCW +: ACCW] = 16'(4 * i + j + 1);
  endtask

  // Runs one job. Bit g of gap_mask drops iValid in LOAD cycle g.
  // The task returns when oValid rises or the cycle budget runs out.
  task automatic run_job(input int k, input logic [15:0] gap_mask);
    int cyc;
    int idx;
    int gi;
    int last;
    bit take;
    @(negedge clk);
    iStart = 1'b1;
    iK     = KW'(k);
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    cyc  = 1;
    idx  = 0;
    gi   = 0;
    last = 0;
    while (idx < k && cyc < 300) begin
      n_checks++;
      if (oReady !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready: oReady=%b required 1 (cycle %0d)", oReady, cyc);
      end
      take   = !gap_mask[gi];
      iValid = take;
      iRow   = take ? rows[idx] : '0;
      iCol   = take ? cols[idx] : '0;
      @(posedge clk);
      if (take) begin
        idx++;
        last = cyc;
      end
      gi++;
      cyc++;
      @(negedge clk);
    end
    iValid = 1'b0;
    iRow   = '0;
    iCol   = '0;
    while (oValid !== 1'b1 && cyc < 300) begin
      if (oReady === 1'b1) saw_ready = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (oValid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: oValid=%b required 1 within budget", oValid);
    end
    lat_start = cyc;
    lat_last  = cyc - last;
  endtask

  // Pulses iAck for one cycle while the bench is on the falling edge.
  task automatic ack_result();
    iAck = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iAck = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    iStart = 1'b0;
    iK     = '0;
    iValid = 1'b0;
    iRow   = '0;
    iCol   = '0;
    iAck   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({oBusy, oReady, oValid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/ready/valid=%b required 000", {oBusy, oReady, oValid});
    end
    n_checks++;
    if (oRes !== '0) begin
      n_fail++;
      $display("FAIL reset_res: oRes=%h required 0", oRes);
    end
    reset = 1'b0;
  endtask

  task automatic test_identity();
    load_identity();
    run_job(4, 16'h0000);
    n_checks++;
    if (lat_last !== 8) begin
      n_fail++;
      $display("FAIL ident_latency: %0d cycles after last beat, required 8", lat_last);
    end
    n_checks++;
    if (lat_start !== 12) begin
      n_fail++;
      $display("FAIL ident_start_latency: %0d cycles after start, required 12", lat_start);
    end
    n_checks++;
    if (oRes !== exp_b) begin
      n_fail++;
      $display("FAIL ident_res: oRes=%h required %h", oRes, exp_b);
    end
    ack_result();
    n_checks++;
    if ({oValid, oBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ident_ack: valid/busy=%b required 00", {oValid, oBusy});
    end
  endtask

  task automatic test_zero_k();
    saw_ready = 1'b0;
    run_job(0, 16'h0000);
    n_checks++;
    if (lat_start !== 8) begin
      n_fail++;
      $display("FAIL zero_k_latency: %0d cycles after start, required 8", lat_start);
    end
    n_checks++;
    if (saw_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_k_ready: oReady seen=%b required 0", saw_ready);
    end
    n_checks++;
    if (oRes !== '0) begin
      n_fail++;
      $display("FAIL zero_k_res: oRes=%h required 0", oRes);
    end
    ack_result();
  endtask

  task automatic test_gaps();
    load_identity();
    run_job(4, 16'b0000_0000_0010_1010);
    n_checks++;
    if (lat_start !== 15) begin
      n_fail++;
      $display("FAIL gaps_latency: %0d cycles after start, required 15", lat_start);
    end
    n_checks++;
    if (lat_last !== 8) begin
      n_fail++;
      $display("FAIL gaps_last_latency: %0d cycles after last beat, required 8", lat_last);
    end
    n_checks++;
    if (oRes !== exp_b) begin
      n_fail++;
      $display("FAIL gaps_res: oRes=%h required %h", oRes, exp_b);
    end
    ack_result();
  endtask

  task automatic test_overflow();
    logic [N*N*ACCW-1:0] exp_ovf;
    for (int k = 0; k < N; k++) begin
      rows[k] = {N{8'h80}};
      cols[k] = {N{8'h80}};
    end
    // Each element is 4 * (-128 * -128) = 65536.
`ifdef SATURATE_EN
    exp_ovf = {(N*N){16'h7FFF}};
`else
    exp_ovf = '0;
`endif
    run_job(4, 16'h0000);
    n_checks++;
    if (oRes !== exp_ovf) begin
      n_fail++;
      $display("FAIL overflow_res: oRes=%h required %h", oRes, exp_ovf);
    end
    ack_result();
  endtask

  task automatic test_reset_mid_run();
    load_identity();
    @(negedge clk);
    iStart = 1'b1;
    iK     = 8'd4;
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    iValid = 1'b1;
    iRow   = rows[0];
    iCol   = cols[0];
    @(posedge clk);
    @(negedge clk);
    iRow  = rows[1];
    iCol  = cols[1];
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    iValid = 1'b0;
    n_checks++;
    if ({oBusy, oReady, oValid} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_flags: busy/ready/valid=%b required 000", {oBusy, oReady, oValid});
    end
    n_checks++;
    if (oRes !== '0) begin
      n_fail++;
      $display("FAIL midreset_res: oRes=%h required 0", oRes);
    end
    run_job(4, 16'h0000);
    n_checks++;
    if (oRes !== exp_b || lat_last !== 8) begin
      n_fail++;
      $display("FAIL midreset_rerun: oRes=%h latency=%0d required %h latency 8", oRes, lat_last, exp_b);
    end
    ack_result();
  endtask

  task automatic test_hold_done();
    load_identity();
    run_job(4, 16'h0000);
    for (int c = 0; c < 10; c++) begin
      iAck   = 1'b0;
      iStart = c[0];
      iK     = 8'd2;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (oValid !== 1'b1 || oBusy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_valid: valid/busy=%b%b required 11 (cycle %0d)", oValid, oBusy, c);
      end
      n_checks++;
      if (oRes !== exp_b) begin
        n_fail++;
        $display("FAIL hold_res: oRes=%h required %h (cycle %0d)", oRes, exp_b, c);
      end
    end
    iStart = 1'b1;
    iAck   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iStart = 1'b0;
    iAck   = 1'b0;
    n_checks++;
    if ({oValid, oBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_ack_start: valid/busy=%b required 00", {oValid, oBusy});
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (oBusy !== 1'b0 || oRes !== exp_b) begin
      n_fail++;
      $display("FAIL hold_idle_after: busy=%b oRes=%h required 0 and %h", oBusy, oRes, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_zero_k();
    test_gaps();
    test_overflow();
    test_reset_mid_run();
    test_hold_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
